// File: rtl/clock_meas_pkg.sv
// clock_meas shared types: FSM states and default counter width.
// Build option CLOCK_MEAS_SYNC_EN adds a 2-flop input synchronizer.
package clock_meas_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    MEAS
  } state_e;

endpackage

// File: rtl/clock_meas_if.sv
// clock_meas result bus: valid/ready handshake carrying period, high time, sat.
// Build option CLOCK_MEAS_SYNC_EN does not change this interface.
interface clock_meas_if
  import clock_meas_pkg::*;
#(
  parameter int W = CNT_W_DEF
) ();

  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] m_period;
  logic [W-1:0] m_high;
  logic         m_sat;

  modport master (
    output m_valid,
    output m_period,
    output m_high,
    output m_sat,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_period,
    input  m_high,
    input  m_sat,
    output m_ready
  );

endinterface

// File: rtl/clock_meas_edge.sv
// sig_in sampling and rising-edge detect for clock_meas.
// CLOCK_MEAS_SYNC_EN inserts a 2-flop synchronizer ahead of s.
module clock_meas_edge (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic s_o,
  output logic rise_o
);

  logic din;
  logic s_q;
  logic sp_q;

`ifdef CLOCK_MEAS_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], sig_in};
    end
  end

  assign din = sync_q[1];
`else
  assign din = sig_in;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q  <= 1'b0;
      sp_q <= 1'b0;
    end else begin
      s_q  <= din;
      sp_q <= s_q;
    end
  end

  assign s_o    = s_q;
  assign rise_o = s_q & ~sp_q;

endmodule

// File: rtl/clock_meas.sv
// Measures sig_in period and high time in clk cycles, one result per rise.
// Build option CLOCK_MEAS_SYNC_EN: sig_in may be asynchronous (+2 latency).
module clock_meas
  import clock_meas_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       sig_in,
  input  logic       ovr_clr,
  output logic       stuck,
  output logic       ovr,
  clock_meas_if.master m
);

  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_e           state_q;
  logic [CNT_W-1:0] per_q;
  logic [CNT_W-1:0] hi_q;
  logic [CNT_W-1:0] mp_q;
  logic [CNT_W-1:0] mh_q;
  logic             ms_q;
  logic             val_q;
  logic             ovr_q;

  logic [CNT_W-1:0] per_d;
  logic [CNT_W-1:0] hi_d;
  logic             per_sat;
  logic             hi_sat;
  logic             s;
  logic             rise;
  logic             cap;
  logic             acc;

  clock_meas_edge u_edge (
    .clk    (clk),
    .rst    (rst),
    .sig_in (sig_in),
    .s_o    (s),
    .rise_o (rise)
  );

  assign per_sat = (per_q == MAX);
  assign hi_sat  = (hi_q == MAX);
  assign per_d   = per_sat ? per_q : per_q + ONE;
  assign hi_d    = (hi_sat || !s) ? hi_q : hi_q + ONE;
  assign cap     = en && (state_q == MEAS) && rise;
  assign acc     = val_q && m.m_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      per_q   <= '0;
      hi_q    <= '0;
      mp_q    <= '0;
      mh_q    <= '0;
      ms_q    <= 1'b0;
      val_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      if (!en) begin
        state_q <= IDLE;
        per_q   <= '0;
        hi_q    <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            state_q <= SYNC;
            per_q   <= '0;
            hi_q    <= '0;
          end
          SYNC: begin
            if (rise) begin
              state_q <= MEAS;
              per_q   <= ONE;
              hi_q    <= ONE;
            end
          end
          MEAS: begin
            if (rise) begin
              per_q <= ONE;
              hi_q  <= ONE;
            end else begin
              per_q <= per_d;
              hi_q  <= hi_d;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
      // an unaccepted result wins over a new capture
      if (cap && (!val_q || acc)) begin
        val_q <= 1'b1;
        mp_q  <= per_q;
        mh_q  <= hi_q;
        ms_q  <= per_sat || hi_sat;
      end else if (acc) begin
        val_q <= 1'b0;
      end
      if (cap && val_q && !acc) begin
        ovr_q <= 1'b1;
      end else if (ovr_clr) begin
        ovr_q <= 1'b0;
      end
    end
  end

  assign stuck      = (state_q == MEAS) && per_sat;
  assign ovr        = ovr_q;
  assign m.m_valid  = val_q;
  assign m.m_period = mp_q;
  assign m.m_high   = mh_q;
  assign m.m_sat    = ms_q;

endmodule

// File: tb/tb_clock_meas.sv
// Scoreboard bench for clock_meas driven by a synchronous clock-generator model.
// Define CLOCK_MEAS_SYNC_EN for both RTL and bench to check the synchronized build.
module tb_clock_meas;

  localparam int CW   = 8;
  localparam int MAXV = (1 << CW) - 1;
`ifdef CLOCK_MEAS_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  typedef struct {
    int p;
    int h;
    int s;
    int due;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic sig_in;
  logic ovr_clr;
  logic stuck;
  logic ovr;

  clock_meas_if #(.W(CW)) mif ();

  clock_meas #(.CNT_W(CW)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .sig_in  (sig_in),
    .ovr_clr (ovr_clr),
    .stuck   (stuck),
    .ovr     (ovr),
    .m       (mif)
  );

  always #5 clk = ~clk;

  int   n_run  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  exp_t q[$];
  exp_t ex;
  bit   mon_en = 1'b1;

  bit src_on    = 1'b0;
  int src_p     = 6;
  int src_d     = 2;
  int scnt      = 0;
  bit have_prev = 1'b0;
  int bp        = 0;
  int bh        = 0;
  int last_rise = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int sat(input int v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  // one clk cycle; the source model drives sig_in just after the edge
  task automatic tick();
    bit nxt;
    @(posedge clk);
    cyc++;
    #1;
    if (src_on) begin
      scnt = (scnt >= src_p) ? 0 : scnt + 1;
      nxt  = (scnt <= src_d);
    end else begin
      nxt = 1'b0;
    end
    if (nxt && !sig_in) begin
      if (have_prev)
        q.push_back('{sat(bp), sat(bh),
                      int'(bp >= MAXV || bh >= MAXV), cyc + LAT});
      have_prev = 1'b1;
      bp        = 1;
      bh        = 1;
      last_rise = cyc;
    end else begin
      bp++;
      if (nxt) bh++;
    end
    sig_in = nxt;
  endtask

  task automatic start_src(input int p, input int d);
    src_p     = p;
    src_d     = d;
    scnt      = p;
    have_prev = 1'b0;
    src_on    = 1'b1;
  endtask

  task automatic restart(input string tag);
    src_on = 1'b0;
    repeat (10) tick();
    chk(tag, q.size(), 0);
    en = 1'b0;
    repeat (2) tick();
    q.delete();
    en = 1'b1;
    repeat (3) tick();
  endtask

  always @(negedge clk) begin
    if (!rst && mon_en && mif.m_valid && mif.m_ready) begin
      if (q.size() == 0) begin
        chk("spurious", 1, 0);
      end else begin
        ex = q.pop_front();
        chk("period", mif.m_period, ex.p);
        chk("high", mif.m_high, ex.h);
        chk("sat", mif.m_sat, ex.s);
        chk("latency", cyc, ex.due);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int guard;
    rst         = 1'b1;
    en          = 1'b0;
    sig_in      = 1'b0;
    ovr_clr     = 1'b0;
    mif.m_ready = 1'b1;
    repeat (2) tick();
    chk("rst_valid", mif.m_valid, 0);
    chk("rst_period", mif.m_period, 0);
    chk("rst_high", mif.m_high, 0);
    chk("rst_sat", mif.m_sat, 0);
    chk("rst_stuck", stuck, 0);
    chk("rst_ovr", ovr, 0);
    rst = 1'b0;
    en  = 1'b1;
    repeat (3) tick();

    // 7-cycle period, 3 high
    start_src(6, 2);
    repeat (60) tick();
    chk("ovr_a", ovr, 0);
    restart("drain_a");

    // minimum duty: 1 high cycle
    start_src(6, 0);
    repeat (40) tick();
    restart("drain_b");

    // constant high: no result, stuck after saturation
    start_src(6, 6);
    tick();
    while (cyc < last_rise + LAT + 253) tick();
    chk("stuck_pre", stuck, 0);
    tick();
    chk("stuck_on", stuck, 1);
    chk("no_result", mif.m_valid, 0);
    src_d = 2;
    repeat (20) tick();
    chk("stuck_clr", stuck, 0);
    restart("drain_c");

    // consumer stalls: first result held, later ones dropped
    mon_en      = 1'b0;
    mif.m_ready = 1'b0;
    start_src(6, 2);
    repeat (30) tick();
    chk("hold_valid", mif.m_valid, 1);
    chk("hold_period", mif.m_period, 7);
    chk("hold_high", mif.m_high, 3);
    chk("ovr_set", ovr, 1);
    src_on = 1'b0;
    repeat (10) tick();
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    chk("ovr_clr", ovr, 0);
    en = 1'b0;
    repeat (2) tick();
    chk("en0_valid", mif.m_valid, 1);
    chk("en0_period", mif.m_period, 7);
    mif.m_ready = 1'b1;
    tick();
    chk("acc_fall", mif.m_valid, 0);
    q.delete();
    mon_en = 1'b1;
    en     = 1'b1;
    repeat (3) tick();

    // reset mid-interval
    start_src(6, 2);
    repeat (30) tick();
    guard = 0;
    while (scnt != 3 && guard < 20) begin
      tick();
      guard++;
    end
    chk("mid_find", int'(scnt == 3), 1);
    chk("pre_rst_period", mif.m_period, 7);
    rst = 1'b1;
    #1;
    chk("mid_valid", mif.m_valid, 0);
    chk("mid_period", mif.m_period, 0);
    chk("mid_high", mif.m_high, 0);
    chk("mid_stuck", stuck, 0);
    chk("mid_ovr", ovr, 0);
    q.delete();
    have_prev = 1'b0;
    tick();
    rst = 1'b0;
    repeat (30) tick();
    restart("drain_e");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
